// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: expands LM/SM register lists into one micro-op per
// selected register, ascending order, and passes every other instruction straight through.
module lm_sm_sequencer #(
    parameter logic [3:0] LM_OPCODE = 4'b0110,
    parameter logic [3:0] SM_OPCODE = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] uop_ir,
    output logic        uop_valid,
    output logic        first_multiple,
    output logic        busy
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEQ  = 1'b1;

    logic       state;
    logic [7:0] pending;
    logic [3:0] op_q;
    logic [2:0] base_q;
    logic [2:0] count;

    logic       is_multi;
    logic [7:0] mask_sel;
    logic [7:0] mask_rest;
    logic [2:0] low_idx;

    assign is_multi  = (ir_in[15:12] == LM_OPCODE) || (ir_in[15:12] == SM_OPCODE);
    assign mask_sel  = (state == ST_IDLE) ? ir_in[7:0] : pending;
    // Clearing the lowest set bit leaves exactly the registers still to be emitted.
    assign mask_rest = mask_sel & (mask_sel - 8'd1);

    always_comb begin
        low_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (mask_sel[7 - i]) begin
                low_idx = 3'(7 - i);
            end
        end
    end

    assign in_ready = !stall && !flush && (state == ST_IDLE);
    assign busy     = (state == ST_SEQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            pending        <= '0;
            op_q           <= '0;
            base_q         <= '0;
            count          <= '0;
            uop_ir         <= '0;
            uop_valid      <= 1'b0;
            first_multiple <= 1'b0;
        end else if (flush) begin
            state          <= ST_IDLE;
            pending        <= '0;
            count          <= '0;
            uop_valid      <= 1'b0;
            first_multiple <= 1'b0;
        end else if (!stall) begin
            if (state == ST_IDLE) begin
                if (!in_valid) begin
                    uop_valid <= 1'b0;
                end else if (!is_multi) begin
                    uop_ir         <= ir_in;
                    uop_valid      <= 1'b1;
                    first_multiple <= 1'b0;
                end else if (ir_in[7:0] == 8'h00) begin
                    uop_valid <= 1'b0;
                end else begin
                    uop_ir         <= {ir_in[15:12], ir_in[11:9], low_idx, 6'd0};
                    uop_valid      <= 1'b1;
                    first_multiple <= 1'b1;
                    op_q           <= ir_in[15:12];
                    base_q         <= ir_in[11:9];
                    count          <= 3'd1;
                    pending        <= mask_rest;
                    state          <= (mask_rest != 8'h00) ? ST_SEQ : ST_IDLE;
                end
            end else begin
                uop_ir         <= {op_q, base_q, low_idx, 3'b000, count};
                uop_valid      <= 1'b1;
                first_multiple <= 1'b0;
                pending        <= mask_rest;
                count          <= count + 3'd1;
                if (mask_rest == 8'h00) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule
